// File: rtl/exec_ctrl.sv
// Execute/writeback controller for the 4x32 register file: one instruction at a time,
// ALU in EXEC, write-back pulse in WB. Define EXEC_MUL_EN to build the iterative multiplier.
module exec_ctrl #(
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned MUL_CYCLES = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ins_valid,
  output logic                 ins_ready,
  input  logic [2:0]           ins_op,
  input  logic [1:0]           ins_rd,
  input  logic [1:0]           ins_rs1,
  input  logic [1:0]           ins_rs2,
  output logic [1:0]           addr1,
  output logic [1:0]           addr2,
  input  logic [WORD_SIZE-1:0] data1,
  input  logic [WORD_SIZE-1:0] data2,
  output logic [1:0]           addr3,
  output logic [WORD_SIZE-1:0] data3,
  output logic                 wr,
  output logic                 done,
  output logic                 busy,
  output logic                 flag_z,
  output logic                 flag_c,
  output logic                 flag_v,
  output logic                 illegal
);

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpSlt = 3'b101;
  localparam logic [2:0] OpSll = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  localparam int unsigned ShW = $clog2(WORD_SIZE);

`ifdef EXEC_MUL_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StExec = 2'd1, StWb = 2'd2, StMul = 2'd3} state_e;
  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MUL_CYCLES - 1);
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StExec = 2'd1, StWb = 2'd2} state_e;
`endif

  state_e               state_q, state_d;
  logic [2:0]           op_q;
  logic [1:0]           rd_q, rs1_q, rs2_q;
  logic [WORD_SIZE-1:0] result_q;
  logic                 z_q, c_q, v_q;

  logic [WORD_SIZE-1:0] alu_res;
  logic                 alu_c, alu_v, alu_z;
  logic [WORD_SIZE:0]   sum;
  logic [WORD_SIZE-1:0] diff;

`ifdef EXEC_MUL_EN
  logic [WORD_SIZE-1:0] mcand_q, mplr_q, acc_q, acc_next;
  logic [CntW-1:0]      cnt_q;

  assign acc_next = acc_q + (mplr_q[0] ? mcand_q : '0);
`endif

  assign addr1  = rs1_q;
  assign addr2  = rs2_q;
  assign addr3  = rd_q;
  assign data3  = result_q;
  assign flag_z = z_q;
  assign flag_c = c_q;
  assign flag_v = v_q;

  // ALU works directly on the asynchronous read data during EXEC.
  always_comb begin
    sum     = {1'b0, data1} + {1'b0, data2};
    diff    = data1 - data2;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_q)
      OpAdd: begin
        alu_res = sum[WORD_SIZE-1:0];
        alu_c   = sum[WORD_SIZE];
        alu_v   = (data1[WORD_SIZE-1] == data2[WORD_SIZE-1]) &&
                  (sum[WORD_SIZE-1] != data1[WORD_SIZE-1]);
      end
      OpSub: begin
        alu_res = diff;
        alu_c   = data1 < data2;
        alu_v   = (data1[WORD_SIZE-1] != data2[WORD_SIZE-1]) &&
                  (diff[WORD_SIZE-1] != data1[WORD_SIZE-1]);
      end
      OpAnd:   alu_res = data1 & data2;
      OpOr:    alu_res = data1 | data2;
      OpXor:   alu_res = data1 ^ data2;
      OpSlt:   alu_res = {{(WORD_SIZE-1){1'b0}}, $signed(data1) < $signed(data2)};
      OpSll:   alu_res = data1 << data2[ShW-1:0];
      default: alu_res = '0;
    endcase
    alu_z = (alu_res == '0);
  end

  always_comb begin
    state_d   = state_q;
    ins_ready = 1'b0;
    wr        = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    busy      = (state_q != StIdle);
    case (state_q)
      StIdle: begin
        // A request coinciding with reset is never accepted.
        ins_ready = !rst;
        if (ins_valid && !rst) state_d = StExec;
      end
      StExec: begin
        if (op_q == OpMul) begin
`ifdef EXEC_MUL_EN
          state_d = StMul;
`else
          illegal = 1'b1;
          done    = 1'b1;
          state_d = StIdle;
`endif
        end else begin
          state_d = StWb;
        end
      end
`ifdef EXEC_MUL_EN
      StMul: begin
        if (cnt_q == CntLast) state_d = StWb;
      end
`endif
      StWb: begin
        wr      = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
`ifdef EXEC_MUL_EN
      mcand_q  <= '0;
      mplr_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && ins_valid) begin
        op_q  <= ins_op;
        rd_q  <= ins_rd;
        rs1_q <= ins_rs1;
        rs2_q <= ins_rs2;
      end
      if (state_q == StExec && op_q != OpMul) begin
        result_q <= alu_res;
        z_q      <= alu_z;
        c_q      <= alu_c;
        v_q      <= alu_v;
      end
`ifdef EXEC_MUL_EN
      if (state_q == StExec && op_q == OpMul) begin
        mcand_q <= data1;
        mplr_q  <= data2;
        acc_q   <= '0;
        cnt_q   <= '0;
      end
      if (state_q == StMul) begin
        acc_q   <= acc_next;
        mcand_q <= mcand_q << 1;
        mplr_q  <= mplr_q >> 1;
        cnt_q   <= cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          result_q <= acc_next;
          z_q      <= (acc_next == '0);
          c_q      <= 1'b0;
          v_q      <= 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl with a behavioural 4x32 register file.
module tb_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ins_valid = 1'b0;
  logic        ins_ready;
  logic [2:0]  ins_op = '0;
  logic [1:0]  ins_rd = '0, ins_rs1 = '0, ins_rs2 = '0;
  logic [1:0]  addr1, addr2, addr3;
  logic [31:0] data1, data2, data3;
  logic        wr, done, busy, flag_z, flag_c, flag_v, illegal;

  logic [31:0] rf [4];
  logic        load = 1'b0;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  rd, rs1, rs2;
    logic [31:0] res;
    logic [2:0]  zcv;
  } vec_t;

  vec_t vecs [16];

  exec_ctrl #(.WORD_SIZE(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_op(ins_op),
    .ins_rd(ins_rd), .ins_rs1(ins_rs1), .ins_rs2(ins_rs2), .addr1(addr1), .addr2(addr2),
    .data1(data1), .data2(data2), .addr3(addr3), .data3(data3), .wr(wr), .done(done),
    .busy(busy), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign data1 = rf[addr1];
  assign data2 = rf[addr2];

  always @(posedge clk) begin
    if (load) begin
      rf[0] <= 32'h12345678;
      rf[1] <= 32'h9ABCDEF0;
      rf[2] <= 32'hFFFFFFFF;
      rf[3] <= 32'h00000001;
    end else if (wr) begin
      rf[addr3] <= data3;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic init_regs();
    @(negedge clk) load = 1'b1;
    @(negedge clk) load = 1'b0;
  endtask

  // Offers one instruction; returns at the negedge of the EXEC cycle with ins_valid low.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, rs1, rs2);
    @(negedge clk);
    ins_valid = 1'b1;
    ins_op = op; ins_rd = rd; ins_rs1 = rs1; ins_rs2 = rs2;
    @(negedge clk);
    ins_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    init_regs();
    issue(v.op, v.rd, v.rs1, v.rs2);
    check({tag, " exec wr"}, {31'b0, wr}, 32'd0);
    check({tag, " exec busy"}, {31'b0, busy}, 32'd1);
    @(negedge clk);
    check({tag, " wb wr/done/illegal"}, {29'b0, wr, done, illegal}, 32'b110);
    check({tag, " addr3"}, {30'b0, addr3}, {30'b0, v.rd});
    check({tag, " data3"}, data3, v.res);
    check({tag, " zcv"}, {29'b0, flag_z, flag_c, flag_v}, {29'b0, v.zcv});
    @(negedge clk);
    check({tag, " idle ready/busy/wr"}, {29'b0, ins_ready, busy, wr}, 32'b100);
  endtask

  initial begin
    int wr_cnt, done_cnt, busy_cnt, wr_k, wr_k2;
    logic [31:0] wr_d, wr_d2;

    vecs[0]  = '{3'b000, 2'd0, 2'd2, 2'd3, 32'h00000000, 3'b110};
    vecs[1]  = '{3'b001, 2'd1, 2'd3, 2'd2, 32'h00000002, 3'b010};
    vecs[2]  = '{3'b101, 2'd2, 2'd2, 2'd3, 32'h00000001, 3'b000};
    vecs[3]  = '{3'b010, 2'd3, 2'd0, 2'd1, 32'h12345670, 3'b000};
    vecs[4]  = '{3'b011, 2'd3, 2'd0, 2'd1, 32'h9ABCDEF8, 3'b000};
    vecs[5]  = '{3'b100, 2'd3, 2'd0, 2'd1, 32'h88888888, 3'b000};
    vecs[6]  = '{3'b110, 2'd3, 2'd0, 2'd3, 32'h2468ACF0, 3'b000};
    vecs[7]  = '{3'b100, 2'd0, 2'd2, 2'd2, 32'h00000000, 3'b100};
    vecs[8]  = '{3'b000, 2'd2, 2'd0, 2'd1, 32'hACF13568, 3'b000};
    vecs[9]  = '{3'b000, 2'd1, 2'd1, 2'd1, 32'h3579BDE0, 3'b011};
    vecs[10] = '{3'b001, 2'd0, 2'd0, 2'd1, 32'h77777788, 3'b010};
    vecs[11] = '{3'b001, 2'd0, 2'd1, 2'd0, 32'h88888878, 3'b000};
    vecs[12] = '{3'b101, 2'd3, 2'd1, 2'd0, 32'h00000001, 3'b000};
    vecs[13] = '{3'b101, 2'd3, 2'd0, 2'd1, 32'h00000000, 3'b100};
    vecs[14] = '{3'b110, 2'd1, 2'd2, 2'd3, 32'hFFFFFFFE, 3'b000};
    vecs[15] = '{3'b110, 2'd1, 2'd3, 2'd2, 32'h80000000, 3'b000};

    // Reset state, sampled while rst is still high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready/busy/wr/done/illegal", {27'b0, ins_ready, busy, wr, done, illegal}, 32'd0);
    check("reset addr1/2/3", {26'b0, addr1, addr2, addr3}, 32'd0);
    check("reset data3", data3, 32'd0);
    check("reset flags", {29'b0, flag_z, flag_c, flag_v}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset ready", {31'b0, ins_ready}, 32'd1);

    for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // MUL (or illegal op when the multiplier is compiled out), starting with flags z=1 c=1.
    run_vec(vecs[0], "pre-mul add");
    init_regs();
    issue(3'b111, 2'd3, 2'd0, 2'd2);
`ifdef EXEC_MUL_EN
    wr_cnt = 0; busy_cnt = 0; wr_k = 0; wr_d = '0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) busy_cnt++;
      if (wr) begin wr_cnt++; wr_k = k; wr_d = data3; end
      @(negedge clk);
    end
    check("mul wr count", wr_cnt, 32'd1);
    check("mul wr cycle", wr_k, 32'd34);
    check("mul data3", wr_d, 32'hEDCBA988);
    check("mul busy cycles", busy_cnt, 32'd34);
    check("mul flags", {29'b0, flag_z, flag_c, flag_v}, 32'd0);
    check("mul rf[3]", rf[3], 32'hEDCBA988);
`else
    check("illegal exec illegal/done/wr", {29'b0, illegal, done, wr}, 32'b110);
    @(negedge clk);
    check("illegal back to idle", {30'b0, ins_ready, busy}, 32'b10);
    check("illegal flags unchanged", {29'b0, flag_z, flag_c, flag_v}, 32'b110);
    wr_cnt = 0;
    repeat (4) begin
      if (wr || illegal) wr_cnt++;
      @(negedge clk);
    end
    check("illegal no wr afterwards", wr_cnt, 32'd0);
    check("illegal rf[3] untouched", rf[3], 32'h00000001);
`endif

    // Back-to-back ADD r3=r3+r3 with ins_valid held high.
    init_regs();
    @(negedge clk);
    ins_valid = 1'b1; ins_op = 3'b000; ins_rd = 2'd3; ins_rs1 = 2'd3; ins_rs2 = 2'd3;
    wr_cnt = 0; wr_k = 0; wr_k2 = 0; wr_d = '0; wr_d2 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 3) check("b2b ready at T+3", {31'b0, ins_ready}, 32'd1);
      if (k == 4) ins_valid = 1'b0;
      if (wr) begin
        wr_cnt++;
        if (wr_cnt == 1) begin wr_k = k; wr_d = data3; end
        else begin wr_k2 = k; wr_d2 = data3; end
      end
    end
    check("b2b wr count", wr_cnt, 32'd2);
    check("b2b first wr cycle", wr_k, 32'd2);
    check("b2b first data", wr_d, 32'h00000002);
    check("b2b second wr cycle", wr_k2, 32'd5);
    check("b2b second data", wr_d2, 32'h00000004);

    // Reset during EXEC of an ADD: the WB must never happen and flags clear.
    run_vec(vecs[0], "pre-rst add");
    init_regs();
    issue(3'b000, 2'd1, 2'd0, 2'd3);
    rst = 1'b1;
    @(negedge clk);
    check("rst exec wr/busy", {30'b0, wr, busy}, 32'd0);
    check("rst exec flags", {29'b0, flag_z, flag_c, flag_v}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst exec rf[1] untouched", rf[1], 32'h9ABCDEF0);

`ifdef EXEC_MUL_EN
    // Reset ten cycles into a MUL.
    run_vec(vecs[0], "pre-mulrst add");
    init_regs();
    issue(3'b111, 2'd3, 2'd0, 2'd2);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mulrst idle", {29'b0, ins_ready, busy, wr}, 32'd0);
    check("mulrst flags", {29'b0, flag_z, flag_c, flag_v}, 32'd0);
    rst = 1'b0;
    wr_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (wr || busy) wr_cnt++;
    end
    check("mulrst no wr", wr_cnt, 32'd0);
    run_vec(vecs[8], "post-mulrst add");
`endif

    // rst and ins_valid together: not accepted.
    @(negedge clk);
    rst = 1'b1; ins_valid = 1'b1; ins_op = 3'b000; ins_rd = 2'd0;
    @(negedge clk);
    rst = 1'b0; ins_valid = 1'b0;
    check("rst+valid busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    check("rst+valid no wr", {30'b0, busy, wr}, 32'd0);

    // ins_valid toggled while busy: exactly one done and one write.
    init_regs();
    issue(3'b000, 2'd3, 2'd3, 2'd3);
    ins_op = 3'b001; ins_rd = 2'd0;
    wr_cnt = 0; done_cnt = 0; wr_d = '0;
    for (int k = 1; k <= 6; k++) begin
      if (done) done_cnt++;
      if (wr) begin wr_cnt++; wr_d = data3; end
      ins_valid = (k == 1);
      @(negedge clk);
    end
    check("toggle done count", done_cnt, 32'd1);
    check("toggle wr count", wr_cnt, 32'd1);
    check("toggle data", wr_d, 32'h00000002);
    check("toggle rf[0] untouched", rf[0], 32'h12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_ctrl.md
# exec_ctrl

Execute-and-writeback controller that sits directly downstream of the 4×32 register file. It accepts one instruction per handshake, drives the file's read addresses, and computes the ALU result from the asynchronous read data. It then writes the result back through the file's write port with a one-cycle `wr` pulse. Instructions run strictly one at a time, so no hazard logic is needed.

## Interface
- `WORD_SIZE`, 32, datapath width; must match the register file.
- `MUL_CYCLES`, 32, iterations of the shift-add multiplier; equals `WORD_SIZE`.
- `clk  in  1  clock`
- `rst  in  1  reset, synchronous, active-high`
- `ins_valid  in  1  instruction offered`
- `ins_ready  out  1  block can accept; high only in IDLE`
- `ins_op  in  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed), 110 SLL, 111 MUL`
- `ins_rd, ins_rs1, ins_rs2  in  2 each  destination/source register numbers`
- `addr1, addr2  out  2 each  to register-file read ports; hold captured rs1/rs2`
- `data1, data2  in  WORD_SIZE each  from register-file read ports`
- `addr3  out  2  write address = captured rd`
- `data3  out  WORD_SIZE  write data`
- `wr  out  1  write-enable pulse`
- `done  out  1  one-cycle pulse, coincident with wr, or with the illegal-op completion`
- `busy  out  1  high in every state except IDLE`
- `flag_z, flag_c, flag_v  out  1 each  zero/carry/overflow of last completed instruction`
- `illegal  out  1  one-cycle pulse: MUL issued with multiplier compiled out`

## Operation
- States: IDLE, EXEC, MUL, WB.
- IDLE: `ins_ready`=1. When `ins_valid`&&`ins_ready`, latch op/rd/rs1/rs2 and go to EXEC.
- EXEC: `data1`/`data2` are valid combinationally from the latched addresses.
  - Non-MUL: compute the result into the result register, compute flags, go to WB.
  - MUL: load multiplicand=`data1`, multiplier=`data2`, accumulator=0, counter=0, go to MUL.
- MUL: each cycle, if multiplier[0] then acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; counter++. After `MUL_CYCLES` iterations, result = acc (low 32 bits) and go to WB.
- WB: `wr`=1, `addr3`=rd, `data3`=result, `done`=1, flags registered. Return to IDLE.
- Arithmetic rules:
  - ADD: {c, r} = a + b; v = signed overflow.
  - SUB: r = a − b; c = borrow (a < b unsigned); v = signed overflow.
  - SLT: r = {31'b0, a <s b}.
  - SLL: r = a << b[4:0].
  - AND/OR/XOR/SLT/SLL/MUL: c = v = 0.
  - All ops: z = (r == 0).
- rd may equal rs1/rs2. The read completes in EXEC, before the write in WB.
- `ins_*` are ignored while `busy`.

## Timing
- Reset values: state IDLE; `ins_ready`=0 in the reset cycle, then 1. All other outputs 0, including `addr*`, `data3` and the flags.
- Accept at edge T → EXEC during cycle T+1 → WB cycle T+2 (`wr`/`done` high) → IDLE at T+3. Throughput is one instruction per 3 cycles.
- MUL: accept T, EXEC T+1, MUL T+2..T+33, WB T+34, IDLE T+35.
- The register file captures `data3` at the edge ending WB. The next instruction's EXEC is at least 2 cycles later, so it reads the updated value.
- `rst` in any state: next cycle is IDLE, no `wr` is issued, the partial product is discarded, and the flags are cleared.
- `rst` and `ins_valid` in the same cycle: the instruction is not accepted.

## Configuration
- `EXEC_MUL_EN` defined: the MUL state and iterative multiplier are built; op 111 behaves as above.
- `EXEC_MUL_EN` undefined: no MUL state or multiplier logic. Op 111 goes IDLE→EXEC→IDLE, where EXEC pulses `illegal`=1 and `done`=1 with `wr`=0, and the flags are unchanged.

## Test plan
Register-file contents are r0=12345678, r1=9ABCDEF0, r2=FFFFFFFF, r3=00000001.
- ADD rd=0, rs1=2, rs2=3 → `wr` at T+2, addr3=0, data3=00000000; z=1, c=1, v=0.
- SUB rd=1, rs1=3, rs2=2 → data3=00000002, c=1 (borrow), v=0, z=0. Then SLT rd=2, rs1=2, rs2=3 → data3=00000001.
- MUL rd=3, rs1=0, rs2=2 (`EXEC_MUL_EN` defined) → `wr` exactly at T+34, data3=EDCBA988; `busy` high T+1..T+34. Without the macro → `illegal`/`done` at T+1, no `wr`.
- Back-to-back: ADD rd=3, rs1=3, rs2=3 twice, with `ins_valid` held high → second accepted at T+3, results 00000002 then 00000004.
- `rst` asserted at T+10 of a MUL → IDLE next cycle, `wr` never asserted, flags 0. A following ADD completes normally.
- `ins_valid` toggled while `busy` → no second `wr`; exactly one `done` per accepted instruction.
